// File: rtl/bndflsh_pkg.sv
// Shared definitions for the bound flasher: state encoding and its width.
package bndflsh_pkg;

  localparam int STATE_W = 3;

  // Code 7 is unused and treated as illegal (recovers to IDLE).
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_UP1  = 3'd1,
    ST_DN1  = 3'd2,
    ST_UP2  = 3'd3,
    ST_DN2  = 3'd4,
    ST_UP3  = 3'd5,
    ST_DN3  = 3'd6
  } state_t;

endpackage

// File: rtl/flash_tick_gen.sv
// Step prescaler: emits one step every STEP_DIV enabled clocks; clr parks it at 0.
module flash_tick_gen #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);

  logic [PW-1:0] r_presc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= (r_presc == LAST) ? '0 : r_presc + 1'b1;
    end
  end

  assign step = en & (r_presc == LAST);

endmodule

// File: rtl/bound_flasher_gen.sv
// N-lamp bound flasher: six-phase up/down thermometer sequence with kickback,
// step prescaler, hold/freeze and busy/done status.
module bound_flasher_gen
  import bndflsh_pkg::*;
#(
  parameter int N_LAMP   = 16,
  parameter int MID_LO   = 5,
  parameter int MID_HI   = 10,
  parameter int STEP_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flick,
  input  logic               hold,
  output logic [N_LAMP-1:0]  a_lamp,
  output logic [STATE_W-1:0] a_next_state,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(N_LAMP + 1);
  localparam logic [CW-1:0] C_TOP = CW'(N_LAMP);
  localparam logic [CW-1:0] C_LO  = CW'(MID_LO);
  localparam logic [CW-1:0] C_HI  = CW'(MID_HI);

  generate
    if (MID_LO <= 0 || MID_LO >= MID_HI || MID_HI >= N_LAMP || STEP_DIV < 1 || N_LAMP < 4) begin : g_param_err
      $error("bound_flasher_gen: illegal parameter set");
    end
  endgenerate

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_up;
  logic [CW-1:0]   w_cnt_dn;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_step;
  logic            w_en;
  logic            w_clr;
  logic [N_LAMP-1:0] w_lamp;

  assign w_en  = ~hold;
  assign w_clr = (r_state == ST_IDLE);

  flash_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .clr  (w_clr),
    .step (w_step)
  );

  assign w_cnt_up = r_cnt + 1'b1;
  assign w_cnt_dn = r_cnt - 1'b1;

  // Turn decisions look at the count the current step is moving to.
  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flick && !hold) begin
          w_next    = ST_UP1;
          w_cnt_nxt = CW'(1);
        end
      end
      ST_UP1: begin
        if (w_step) begin
          w_cnt_nxt = w_cnt_up;
          if (w_cnt_up == C_TOP) w_next = ST_DN1;
        end
      end
      ST_DN1: begin
        if (w_step) begin
          w_cnt_nxt = w_cnt_dn;
          if (w_cnt_dn == C_LO) w_next = flick ? ST_UP1 : ST_UP2;
        end
      end
      ST_UP2: begin
        if (w_step) begin
          w_cnt_nxt = w_cnt_up;
          if (w_cnt_up == C_HI) w_next = ST_DN2;
        end
      end
      ST_DN2: begin
        if (w_step) begin
          w_cnt_nxt = w_cnt_dn;
          if (w_cnt_dn == C_LO && flick) w_next = ST_UP2;
          else if (w_cnt_dn == '0)       w_next = flick ? ST_UP2 : ST_UP3;
        end
      end
      ST_UP3: begin
        if (w_step) begin
          w_cnt_nxt = w_cnt_up;
          if (w_cnt_up == C_LO) w_next = ST_DN3;
        end
      end
      ST_DN3: begin
        if (w_step) begin
          w_cnt_nxt = w_cnt_dn;
          if (w_cnt_dn == '0) begin
            w_next     = ST_IDLE;
            w_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_next    = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_lamp = '0;
    for (int i = 0; i < N_LAMP; i++) begin
      w_lamp[i] = (int'(r_cnt) > i);
    end
  end

  assign a_lamp       = w_lamp;
  assign a_next_state = rst ? '0 : w_next;
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Bench for bound_flasher_gen: two configurations driven in lockstep and
// compared every cycle against a phase/count reference model.
module tb_bound_flasher_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        flick;
  logic        hold;
  logic [15:0] lamp0;
  logic [31:0] lamp1;
  logic [2:0]  nxt0, nxt1;
  logic        busy0, busy1, done0, done1;

  bound_flasher_gen u_dut0 (
    .clk(clk), .rst(rst), .flick(flick), .hold(hold),
    .a_lamp(lamp0), .a_next_state(nxt0), .busy(busy0), .done(done0)
  );

  bound_flasher_gen #(.N_LAMP(32), .MID_LO(8), .MID_HI(20), .STEP_DIV(3)) u_dut1 (
    .clk(clk), .rst(rst), .flick(flick), .hold(hold),
    .a_lamp(lamp1), .a_next_state(nxt1), .busy(busy1), .done(done1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  int p_nl[2] = '{16, 32};
  int p_lo[2] = '{5, 8};
  int p_hi[2] = '{10, 20};
  int p_dv[2] = '{1, 3};

  // phase 0 = idle, 1..6 = UP1 DN1 UP2 DN2 UP3 DN3 (odd phases count up)
  int m_ph[2], m_cnt[2], m_pr[2], m_done[2];
  int n_ph[2], n_cnt[2], n_pr[2], n_done[2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] therm(input int c);
    return (64'd1 << c) - 64'd1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_cnt[k] = 0; m_pr[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_next(input int k, input logic f, input logic h);
    int c;
    n_ph[k] = m_ph[k]; n_cnt[k] = m_cnt[k]; n_pr[k] = m_pr[k]; n_done[k] = 0;
    if (m_ph[k] == 0) begin
      n_pr[k] = 0;
      if (f && !h) begin
        n_ph[k] = 1;
        n_cnt[k] = 1;
      end
    end else if (!h) begin
      if (m_pr[k] < p_dv[k] - 1) begin
        n_pr[k] = m_pr[k] + 1;
      end else begin
        n_pr[k] = 0;
        c = m_cnt[k] + ((m_ph[k] % 2 == 1) ? 1 : -1);
        n_cnt[k] = c;
        case (m_ph[k])
          1: if (c == p_nl[k]) n_ph[k] = 2;
          2: if (c == p_lo[k]) n_ph[k] = f ? 1 : 3;
          3: if (c == p_hi[k]) n_ph[k] = 4;
          4: begin
            if (c == p_lo[k] && f) n_ph[k] = 3;
            else if (c == 0)       n_ph[k] = f ? 3 : 5;
          end
          5: if (c == p_lo[k]) n_ph[k] = 6;
          6: if (c == 0) begin n_ph[k] = 0; n_done[k] = 1; end
          default: n_ph[k] = 0;
        endcase
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycle(input logic f, input logic h);
    @(negedge clk);
    flick = f;
    hold  = h;
    #1;
    for (int k = 0; k < 2; k++) model_next(k, f, h);
    exp_q.push_back(32'(therm(m_cnt[0])));
    exp_q.push_back(32'(therm(m_cnt[1])));
    check_val("lamp0", {48'd0, lamp0}, {32'd0, exp_q.pop_front()});
    check_val("lamp1", {32'd0, lamp1}, {32'd0, exp_q.pop_front()});
    check_val("busy0", busy0, m_ph[0] != 0);
    check_val("busy1", busy1, m_ph[1] != 0);
    check_val("done0", done0, m_done[0] != 0);
    check_val("done1", done1, m_done[1] != 0);
    check_val("next0", nxt0, n_ph[0][2:0]);
    check_val("next1", nxt1, n_ph[1][2:0]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = n_ph[k]; m_cnt[k] = n_cnt[k]; m_pr[k] = n_pr[k]; m_done[k] = n_done[k];
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_lamp0"}, {48'd0, lamp0}, 64'd0);
    check_val({tag, "_lamp1"}, {32'd0, lamp1}, 64'd0);
    check_val({tag, "_busy"},  {busy0, busy1}, 2'b00);
    check_val({tag, "_done"},  {done0, done1}, 2'b00);
    check_val({tag, "_next"},  {nxt0, nxt1}, 6'd0);
  endtask

  // Reset lands between clock edges so only the asynchronous path can clear the bar.
  task automatic pulse_reset();
    @(negedge clk);
    flick = 1'b0;
    hold  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    flick = 1'b0;
    hold  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;

    // Single flick pulse, then let both channels run to completion.
    run_cycle(1'b1, 1'b0);
    repeat (400) run_cycle(1'b0, 1'b0);

    // Flick held high: repeated kickbacks, then release.
    repeat (300) run_cycle(1'b1, 1'b0);
    repeat (450) run_cycle(1'b0, 1'b0);

    // Reset in the middle of UP1 (cnt=8 on the default channel), then restart.
    run_cycle(1'b1, 1'b0);
    repeat (7) run_cycle(1'b0, 1'b0);
    pulse_reset();
    run_cycle(1'b1, 1'b0);
    repeat (20) run_cycle(1'b0, 1'b0);

    // Randomized flick/hold traffic.
    repeat (3000) run_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);

    // Bursty flick with sparse hold.
    for (int b = 0; b < 40; b++) begin
      logic f;
      f = $urandom_range(0, 1) == 1;
      repeat ($urandom_range(1, 25)) run_cycle(f, $urandom_range(0, 9) == 0);
    end

    pulse_reset();
    repeat (200) run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    // Drain: both channels must return to idle.
    repeat (500) run_cycle(1'b0, 1'b0);
    check_val("final_busy", {busy0, busy1}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
